// File: rtl/gerenciador_chamadas.sv
// Call dispatcher for the 4-floor elevator: latches calls, picks the next floor with a SCAN policy
// and holds the door open for TEMPO_PORTA cycles per stop. Optional emergency recall: EMERGENCIA_EN.
module gerenciador_chamadas #(
  parameter int TEMPO_PORTA = 8
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic [3:0] botao_chamada,
  input  logic [1:0] andar,
  input  logic       parado,
  input  logic       subindo,
  input  logic       porta_fechada,
`ifdef EMERGENCIA_EN
  input  logic       emergencia,
`endif
  output logic [1:0] seletor_andar,
  output logic       pessoa_para_descer,
  output logic [3:0] chamadas_pendentes,
  output logic       ocupado
);

  // state      | meaning
  // OCIOSO     | idle, waiting for a call
  // DESLOCANDO | travelling towards seletor_andar
  // EMBARQUE   | stopped at a floor, door held open for the dwell time
  // FECHANDO   | dwell over, waiting for the door-closed sensor
  typedef enum logic [1:0] {OCIOSO, DESLOCANDO, EMBARQUE, FECHANDO} state_t;

  localparam int            TW     = $clog2(TEMPO_PORTA + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TEMPO_PORTA - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  state_t        state_q, state_d;
  logic [3:0]    pend_q, pend_d;
  logic          dir_sobe_q, dir_sobe_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    sel_q, sel_d;
  logic          ppd_q, ppd_d;

  logic [3:0] onehot_andar, botao_m, pend_in, limpa;
  logic       up_ok, dn_ok, tgt_ok, tgt_dir, entrando;
  logic [1:0] up_tgt, dn_tgt, tgt;

  logic unused_subindo;
  assign unused_subindo = subindo;

`ifdef EMERGENCIA_EN
  logic emg_q;
`endif

  assign onehot_andar = 4'b0001 << andar;
  // A press at the current floor during boarding only extends the dwell; it is never latched.
  assign botao_m = botao_chamada & ~((state_q == EMBARQUE) ? onehot_andar : 4'b0000);
  assign pend_in = pend_q | botao_m;

  always_comb begin
    up_ok  = 1'b0;
    up_tgt = andar;
    dn_ok  = 1'b0;
    dn_tgt = andar;
    for (int i = 3; i >= 0; i--) begin
      if (2'(i) > andar && pend_in[2'(i)]) begin
        up_ok  = 1'b1;
        up_tgt = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < andar && pend_in[2'(i)]) begin
        dn_ok  = 1'b1;
        dn_tgt = 2'(i);
      end
    end
    tgt_ok  = 1'b0;
    tgt     = andar;
    tgt_dir = dir_sobe_q;
    if (dir_sobe_q) begin
      if (up_ok) begin
        tgt_ok = 1'b1; tgt = up_tgt; tgt_dir = 1'b1;
      end else if (dn_ok) begin
        tgt_ok = 1'b1; tgt = dn_tgt; tgt_dir = 1'b0;
      end
    end else begin
      if (dn_ok) begin
        tgt_ok = 1'b1; tgt = dn_tgt; tgt_dir = 1'b0;
      end else if (up_ok) begin
        tgt_ok = 1'b1; tgt = up_tgt; tgt_dir = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    dir_sobe_d = dir_sobe_q;
    timer_d    = timer_q;
    case (state_q)
      OCIOSO: begin
        if (pend_in[andar]) begin
          state_d = EMBARQUE;
          sel_d   = andar;
        end else if (tgt_ok) begin
          state_d    = DESLOCANDO;
          sel_d      = tgt;
          dir_sobe_d = tgt_dir;
        end else begin
          sel_d = andar;
        end
      end
      DESLOCANDO: begin
        // Hold the selection once on the target floor so it is not re-targeted past it.
        if (andar == sel_q) begin
          if (parado) state_d = EMBARQUE;
        end else if (tgt_ok) begin
          sel_d      = tgt;
          dir_sobe_d = tgt_dir;
        end
      end
      EMBARQUE: begin
        if (botao_chamada[andar]) timer_d = T_LOAD;
        else if (timer_q == '0)   state_d = FECHANDO;
        else                      timer_d = timer_q - T_ONE;
`ifdef EMERGENCIA_EN
        if (emg_q && !emergencia) state_d = FECHANDO;
`endif
      end
      FECHANDO: begin
        sel_d = andar;
        if (porta_fechada) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase

`ifdef EMERGENCIA_EN
    if (emergencia) begin
      sel_d   = 2'b00;
      state_d = (andar == 2'b00 && parado) ? EMBARQUE : DESLOCANDO;
    end
`endif

    entrando = (state_d == EMBARQUE) && (state_q != EMBARQUE);
    limpa    = entrando ? onehot_andar : 4'b0000;
    if (entrando) timer_d = T_LOAD;
    pend_d = pend_in & ~limpa;
`ifdef EMERGENCIA_EN
    if (emergencia) pend_d = 4'b0000;
`endif
    ppd_d = (state_d == EMBARQUE);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OCIOSO;
      pend_q     <= 4'b0000;
      dir_sobe_q <= 1'b1;
      timer_q    <= '0;
      sel_q      <= 2'b00;
      ppd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      dir_sobe_q <= dir_sobe_d;
      timer_q    <= timer_d;
      sel_q      <= sel_d;
      ppd_q      <= ppd_d;
    end
  end

`ifdef EMERGENCIA_EN
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) emg_q <= 1'b0;
    else          emg_q <= emergencia;
  end
`endif

  assign seletor_andar      = sel_q;
  assign pessoa_para_descer = ppd_q;
  assign chamadas_pendentes = pend_q;
  assign ocupado            = (state_q != OCIOSO) || (pend_q != 4'b0000);

endmodule

// File: doc/gerenciador_chamadas.md
Name: gerenciador_chamadas

Overview:
- Call dispatcher for the 4-floor elevator; drives the floor controller's requested-floor input.
- Latches floor/cabin call buttons and picks the next target floor using a SCAN (keep-direction) policy.
- Drives the floor controller's `pessoa_para_descer` input to hold the door open for a fixed dwell time at each serviced floor.
- Consumes the controller's status: current floor, moving-up flag, stopped flag and door-closed flag.

Parameters:
- TEMPO_PORTA, 8, door dwell length in clock_in cycles (≥1); timer width = $clog2(TEMPO_PORTA+1).

Ports:
- clock_in  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- botao_chamada  input  4  one bit per floor (bit i = floor i); level or pulse; sampled every cycle.
- andar  input  2  current floor reported by the floor controller.
- parado  input  1  controller's stopped flag (P).
- subindo  input  1  controller's moving-up flag (S); status only, not used for decisions.
- porta_fechada  input  1  door closed sensor.
- seletor_andar  output  2  registered target floor sent to the floor controller.
- pessoa_para_descer  output  1  registered; high = hold elevator, door open.
- chamadas_pendentes  output  4  registered pending-call mask.
- ocupado  output  1  high when state ≠ OCIOSO or any call is pending.

Behaviour:
- Reset (reset_n low, async):
  - state=OCIOSO, pendentes=0000, dir_sobe=1, timer=0.
  - seletor_andar=00, pessoa_para_descer=0, ocupado=0.
- Call latch, every edge: pendentes <= (pendentes | botao_chamada) & ~limpa.
  - limpa = one-hot of andar when entering EMBARQUE, else 0.
  - A call for andar arriving while in EMBARQUE is not latched; it reloads timer to TEMPO_PORTA-1.
- Target selection (combinational, from pendentes and andar):
  - Search in dir_sobe direction for the nearest pending floor strictly beyond andar.
  - If none, reverse: toggle dir_sobe and take the nearest pending floor in the other direction.
  - If none in either direction, there is no target.
- States:
  - OCIOSO:
    - If pendentes[andar] (including a call arriving this cycle) → EMBARQUE.
    - Else if a target exists → DESLOCANDO and seletor_andar <= target.
    - Else seletor_andar <= andar.
  - DESLOCANDO:
    - seletor_andar <= target, re-evaluated every cycle, so a nearer same-direction call is picked up en route.
    - When andar==seletor_andar and parado==1 → EMBARQUE.
  - EMBARQUE:
    - On entry: clear pendentes[andar], timer <= TEMPO_PORTA-1, pessoa_para_descer <= 1.
    - Decrement timer each cycle; at timer==0 → FECHANDO, pessoa_para_descer <= 0.
  - FECHANDO:
    - seletor_andar <= andar.
    - Wait for porta_fechada==1, then → OCIOSO.
- Latency: one cycle from a botao_chamada edge to chamadas_pendentes/seletor_andar update.
- Boundaries:
  - At floor 3 with dir_sobe=1 and nothing above: direction flips same cycle.
  - At floor 0 with dir_sobe=0: symmetric flip.
  - Simultaneous calls on all floors: serviced in SCAN order, one EMBARQUE each.
  - porta_fechada stuck low: remain in FECHANDO indefinitely.
  - reset_n asserted mid-travel: all calls lost; outputs return to reset values immediately.

Optional Feature:
- Macro: EMERGENCIA_EN.
- When defined:
  - Adds input port `emergencia` (1 bit).
  - While high: pendentes forced to 0000, botao_chamada ignored, seletor_andar <= 00, pessoa_para_descer <= 0, state forced to DESLOCANDO.
  - On reaching andar==00 with parado=1: → EMBARQUE and hold pessoa_para_descer=1 until emergencia falls.
  - Then → FECHANDO.
- When undefined: no port, no logic.

Test Plan:
- Reset at andar=10 → seletor_andar=00, chamadas_pendentes=0000, pessoa_para_descer=0, ocupado=0.
- Start andar=00, press botao_chamada=0100 for one cycle → chamadas_pendentes=0100, seletor_andar=10 next cycle. Drive andar=10, parado=1 → pessoa_para_descer=1 for exactly 8 cycles, pendentes=0000.
- At andar=01 going up, pendentes=1001 → seletor_andar=11 first. After dwell and porta_fechada=1 → seletor_andar=00 (direction reversal).
- In DESLOCANDO toward 11 from 00, press floor 2 while andar=01 → seletor_andar changes 11→10 next cycle.
- During EMBARQUE at floor 1, press botao_chamada=0010 with 3 cycles left → timer reloads; pessoa_para_descer stays high 8 more cycles; pendentes stays 0000.
- (EMERGENCIA_EN) emergencia=1 with pendentes=1110 at andar=11 → pendentes=0000, seletor_andar=00. Door held open at floor 0 until emergencia=0.
